// File: rtl/key_seq_detector_pkg.sv
// Shared defaults and helpers for the key-driven serial sequence detector.
package key_seq_detector_pkg;

    localparam int         DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
    localparam int         DEF_PATTERN_W       = 8;
    localparam logic [7:0] DEF_PATTERN         = 8'b1101_0101;
    localparam int         DEF_LED_HOLD_CYCLES = 25_000_000;
    localparam int         DEF_CNT_W           = 8;

    // Width needed to hold a progress value in 0..pattern_w.
    function automatic int sc_width(input int pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/key_seq_detector_if.sv
// Board-side bundle: raw key/switch pins in, debounce/progress/match status out.
interface key_seq_detector_if
    import key_seq_detector_pkg::*;
#(
    parameter int PATTERN_W = DEF_PATTERN_W,
    parameter int CNT_W     = DEF_CNT_W
);
    localparam int SC_W = sc_width(PATTERN_W);

    logic             key;
    logic             sw;
    logic             key_stable;
    logic             bit_valid;
    logic [SC_W-1:0]  state_count;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             led;

    modport master (
        output key, sw,
        input  key_stable, bit_valid, state_count, match, match_cnt, led
    );

    modport slave (
        input  key, sw,
        output key_stable, bit_valid, state_count, match, match_cnt, led
    );
endinterface

// File: rtl/key_seq_detector_debounce.sv
// Push-button front end: 2-flop synchroniser, stable-level debounce counter
// and a one-cycle pulse in the cycle after the debounced level falls.
module key_debounce
    import key_seq_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_stable,
    output logic fall_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_key;

    assign w_key = r_sync[1];

    // Bring the asynchronous key into clk; idle level (released) is 1.
    always_ff @(posedge clk) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], key_in};
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (w_key != r_stable) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= w_key;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered press detect: pulse lands one cycle after key_stable falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stable_d <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_fall     <= r_stable_d & ~r_stable;
        end
    end

    assign key_stable = r_stable;
    assign fall_pulse = r_fall;
endmodule

// File: rtl/key_seq_detector.sv
// Serial sequence detector: each debounced press shifts the switch level into
// a history, progress is the longest history suffix equal to a pattern prefix.
module key_seq_detector
    import key_seq_detector_pkg::*;
#(
    parameter int                   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                   PATTERN_W       = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN         = PATTERN_W'(DEF_PATTERN),
    parameter int                   OVERLAP         = 1,
    parameter int                   LED_HOLD_CYCLES = DEF_LED_HOLD_CYCLES,
    parameter int                   CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    key_seq_detector_if.slave  bus
);
    localparam int SC_W   = sc_width(PATTERN_W);
    localparam int HOLD_W = (LED_HOLD_CYCLES > 0) ? $clog2(LED_HOLD_CYCLES + 1) : 1;

    logic [1:0]           r_sw_sync;
    logic                 w_sw;
    logic                 w_key_stable;
    logic                 w_bit_valid;
    logic [PATTERN_W-1:0] r_hist;
    logic [PATTERN_W-1:0] w_hist_nx;
    logic [SC_W-1:0]      r_fill;
    logic [SC_W-1:0]      w_fill_nx;
    logic                 w_match_nx;
    logic [PATTERN_W:1]   w_hit;
    logic [SC_W-1:0]      w_sc;
    logic                 r_match;
    logic [CNT_W-1:0]     r_match_cnt;
    logic [HOLD_W-1:0]    r_hold;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (bus.key),
        .key_stable (w_key_stable),
        .fall_pulse (w_bit_valid)
    );

    // Switch synchroniser; the data bit idles at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) r_sw_sync <= 2'b00;
        else        r_sw_sync <= {r_sw_sync[0], bus.sw};
    end
    assign w_sw = r_sw_sync[1];

    // Post-shift history/fill and the full-pattern hit that they imply.
    always_comb begin
        w_hist_nx  = {r_hist[PATTERN_W-2:0], w_sw};
        w_fill_nx  = (r_fill == SC_W'(PATTERN_W)) ? r_fill : r_fill + 1'b1;
        w_match_nx = w_bit_valid && (w_hist_nx == PATTERN) &&
                     (w_fill_nx == SC_W'(PATTERN_W));
    end

    // Shift on each accepted press; non-overlap mode forgets the history on a hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_bit_valid) begin
            r_hist <= w_hist_nx;
            r_fill <= (w_match_nx && (OVERLAP == 0)) ? '0 : w_fill_nx;
        end
    end

    // One comparator per candidate prefix length; only filled bits may count.
    for (genvar L = 1; L <= PATTERN_W; L++) begin : g_pfx
        localparam logic [L-1:0] PFX = PATTERN[PATTERN_W-1 -: L];
        assign w_hit[L] = (r_fill >= SC_W'(L)) && (r_hist[L-1:0] == PFX);
    end

    // Progress is the longest matching prefix length.
    always_comb begin
        w_sc = '0;
        for (int l = 1; l <= PATTERN_W; l++) begin
            if (w_hit[l]) w_sc = SC_W'(l);
        end
    end

    // Match pulse, saturating match counter and retriggerable led hold timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match     <= 1'b0;
            r_match_cnt <= '0;
            r_hold      <= '0;
        end else begin
            r_match <= w_match_nx;
            if (w_match_nx && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
            if (w_match_nx)          r_hold <= HOLD_W'(LED_HOLD_CYCLES);
            else if (r_hold != '0)   r_hold <= r_hold - 1'b1;
        end
    end

    assign bus.key_stable  = w_key_stable;
    assign bus.bit_valid   = w_bit_valid;
    assign bus.state_count = w_sc;
    assign bus.match       = r_match;
    assign bus.match_cnt   = r_match_cnt;
    assign bus.led         = (LED_HOLD_CYCLES == 0) ? r_match : (r_hold != '0);
endmodule

// File: tb/tb_key_seq_detector.sv
// Directed bench: four detector configurations share one key/switch stimulus;
// table-driven press sequences plus hand-written debounce/retrigger/reset cases.
module tb_key_seq_detector;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_seq_detector_if #(.PATTERN_W(8), .CNT_W(8)) ifa ();
    key_seq_detector_if #(.PATTERN_W(4), .CNT_W(2)) ifb ();
    key_seq_detector_if #(.PATTERN_W(4), .CNT_W(8)) ifc ();
    key_seq_detector_if #(.PATTERN_W(2), .CNT_W(2)) ifd ();

    key_seq_detector #(.DEBOUNCE_CYCLES(8), .PATTERN_W(8), .PATTERN(8'b1101_0101),
        .OVERLAP(1), .LED_HOLD_CYCLES(20), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    key_seq_detector #(.DEBOUNCE_CYCLES(8), .PATTERN_W(4), .PATTERN(4'b1010),
        .OVERLAP(1), .LED_HOLD_CYCLES(20), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    key_seq_detector #(.DEBOUNCE_CYCLES(8), .PATTERN_W(4), .PATTERN(4'b1010),
        .OVERLAP(0), .LED_HOLD_CYCLES(20), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    key_seq_detector #(.DEBOUNCE_CYCLES(2), .PATTERN_W(2), .PATTERN(2'b11),
        .OVERLAP(1), .LED_HOLD_CYCLES(20), .CNT_W(2)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    int ncmp = 0;
    int nfail = 0;
    // per-window accumulators, sampled once per cycle on the falling edge
    int pa, pb, pc, pd, la, ld, ks_low, bv_a, bad_a;

    typedef struct { logic sw; int sc; int cnt; int mp; int led; } va_t;
    typedef struct { logic sw; int sc_b; int cnt_b; int mp_b; int sc_c; int cnt_c; int mp_c; } vbc_t;
    va_t  ta [18];
    vbc_t tbc[12];

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_key(input logic k);
        ifa.key = k; ifb.key = k; ifc.key = k; ifd.key = k;
    endtask

    task automatic set_sw(input logic s);
        ifa.sw = s; ifb.sw = s; ifc.sw = s; ifd.sw = s;
    endtask

    task automatic clr();
        pa = 0; pb = 0; pc = 0; pd = 0; la = 0; ld = 0; ks_low = 0; bv_a = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            pa += int'(ifa.match); pb += int'(ifb.match);
            pc += int'(ifc.match); pd += int'(ifd.match);
            la += int'(ifa.led);   ld += int'(ifd.led);
            ks_low += int'(!ifa.key_stable);
            bv_a   += int'(ifa.bit_valid);
            if (ifa.match && !ifa.led) bad_a++;
        end
    endtask

    task automatic press(input logic b, input int lo, input int hi);
        set_sw(b);
        set_key(1'b0);
        run(lo);
        set_key(1'b1);
        run(hi);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        // pattern 1101_0101, overlap: first full entry, then 1,1 and the pattern again
        ta = '{'{1'b1,1,0,0,0}, '{1'b1,2,0,0,0}, '{1'b0,3,0,0,0}, '{1'b1,4,0,0,0},
               '{1'b0,5,0,0,0}, '{1'b1,6,0,0,0}, '{1'b0,7,0,0,0}, '{1'b1,8,1,1,20},
               '{1'b1,2,1,0,0}, '{1'b1,2,1,0,0}, '{1'b1,2,1,0,0}, '{1'b1,2,1,0,0},
               '{1'b0,3,1,0,0}, '{1'b1,4,1,0,0}, '{1'b0,5,1,0,0}, '{1'b1,6,1,0,0},
               '{1'b0,7,1,0,0}, '{1'b1,8,2,1,20}};
        // pattern 1010: overlap (2-bit saturating counter) vs non-overlap
        tbc = '{'{1'b1,1,0,0,1,0,0}, '{1'b0,2,0,0,2,0,0}, '{1'b1,3,0,0,3,0,0},
                '{1'b0,4,1,1,0,1,1}, '{1'b1,3,1,0,1,1,0}, '{1'b0,4,2,1,2,1,0},
                '{1'b1,3,2,0,3,1,0}, '{1'b0,4,3,1,0,2,1}, '{1'b1,3,3,0,1,2,0},
                '{1'b0,4,3,1,2,2,0}, '{1'b1,3,3,0,3,2,0}, '{1'b0,4,3,1,0,3,1}};
        bad_a = 0;
        clr();
        set_key(1'b1);
        set_sw(1'b0);

        // reset values
        do_reset(3);
        run(2);
        chk("reset key_stable",  int'(ifa.key_stable), 1);
        chk("reset bit_valid",   int'(ifa.bit_valid), 0);
        chk("reset state_count", int'(ifa.state_count), 0);
        chk("reset match",       int'(ifa.match), 0);
        chk("reset match_cnt",   int'(ifa.match_cnt), 0);
        chk("reset led",         int'(ifa.led), 0);

        // short glitch is filtered
        clr();
        set_key(1'b0);
        run(5);
        set_key(1'b1);
        run(20);
        chk("glitch key_stable low cycles", ks_low, 0);
        chk("glitch bit_valid pulses", bv_a, 0);

        // long press: key_stable falls on edge 10, bit_valid on edge 11 only
        set_key(1'b0);
        for (int i = 1; i <= 30; i++) begin
            run(1);
            if (i == 9)  chk("press key_stable edge9", int'(ifa.key_stable), 1);
            if (i == 10) chk("press key_stable edge10", int'(ifa.key_stable), 0);
            if (i == 10) chk("press bit_valid edge10", int'(ifa.bit_valid), 0);
            if (i == 11) chk("press bit_valid edge11", int'(ifa.bit_valid), 1);
            if (i == 12) chk("press bit_valid edge12", int'(ifa.bit_valid), 0);
        end
        set_key(1'b1);
        run(12);

        // 8-bit pattern, overlap mode
        do_reset(2);
        for (int i = 0; i < 18; i++) begin
            clr();
            press(ta[i].sw, 30, 10);
            chk($sformatf("A bit%0d state_count", i + 1), int'(ifa.state_count), ta[i].sc);
            chk($sformatf("A bit%0d match_cnt", i + 1), int'(ifa.match_cnt), ta[i].cnt);
            chk($sformatf("A bit%0d match pulses", i + 1), pa, ta[i].mp);
            chk($sformatf("A bit%0d led cycles", i + 1), la, ta[i].led);
        end
        chk("A match without led", bad_a, 0);

        // reset mid-sequence discards partial history
        do_reset(2);
        press(1'b1, 30, 10);
        press(1'b1, 30, 10);
        press(1'b0, 30, 10);
        chk("midreset state_count before", int'(ifa.state_count), 3);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        chk("midreset state_count after", int'(ifa.state_count), 0);
        clr();
        press(1'b1, 30, 10); press(1'b1, 30, 10); press(1'b0, 30, 10); press(1'b1, 30, 10);
        press(1'b0, 30, 10); press(1'b1, 30, 10); press(1'b0, 30, 10); press(1'b1, 30, 10);
        chk("midreset match pulses", pa, 1);
        chk("midreset match_cnt", int'(ifa.match_cnt), 1);

        // 4-bit pattern, overlap vs non-overlap
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            clr();
            press(tbc[i].sw, 30, 10);
            chk($sformatf("B bit%0d state_count", i + 1), int'(ifb.state_count), tbc[i].sc_b);
            chk($sformatf("B bit%0d match_cnt", i + 1), int'(ifb.match_cnt), tbc[i].cnt_b);
            chk($sformatf("B bit%0d match pulses", i + 1), pb, tbc[i].mp_b);
            chk($sformatf("C bit%0d state_count", i + 1), int'(ifc.state_count), tbc[i].sc_c);
            chk($sformatf("C bit%0d match_cnt", i + 1), int'(ifc.match_cnt), tbc[i].cnt_c);
            chk($sformatf("C bit%0d match pulses", i + 1), pc, tbc[i].mp_c);
        end

        // led retrigger: matches 10 cycles apart keep led lit until 20 after the last
        do_reset(2);
        clr();
        press(1'b1, 5, 5); press(1'b1, 5, 5); press(1'b1, 5, 5);
        run(40);
        chk("D retrigger match pulses", pd, 2);
        chk("D retrigger led cycles", ld, 30);
        chk("D match_cnt 2", int'(ifd.match_cnt), 2);
        clr();
        press(1'b1, 5, 5); press(1'b1, 5, 5); press(1'b1, 5, 5);
        run(40);
        chk("D second burst pulses", pd, 3);
        chk("D second burst led cycles", ld, 40);
        chk("D match_cnt saturated", int'(ifd.match_cnt), 3);

        // reset turns a lit led off at once
        press(1'b1, 5, 5);
        chk("D led lit before reset", int'(ifd.led), 1);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        chk("D led after reset", int'(ifd.led), 0);
        chk("D match_cnt after reset", int'(ifd.match_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
